ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
//  Decode-stage control unit for the 5-stage RV32 pipeline, generalised from the flat opcode decoder.
//  Decodes the ID opcode into a control bundle and registers it into the ID/EX stage.
//  Detects load-use hazards (stall + bubble) and branch flushes (bubble for FLUSH_CYCLES).
//  Sits between the IF/ID register and the EX stage; drives PC / IF-ID write enables.
// PARAMETERS
//  ALUOP_W      2  width of the ALUOp field sent to the ALU control
//  REG_W        5  register-index width (rs1/rs2/rd)
//  FLUSH_CYCLES 1  bubbles injected after branch_taken (1..7)
//  CNT_W        16 width of saturating stall/flush performance counters
// PORTS
//  clk            in  1        pipeline clock
//  reset_n        in  1        async active-low reset
//  id_valid       in  1        IF/ID holds a valid instruction
//  id_opcode      in  7        instr[6:0]
//  id_rs1         in  REG_W    instr[19:15]
//  id_rs2         in  REG_W    instr[24:20]
//  id_rd          in  REG_W    instr[11:7]
//  branch_taken   in  1        branch resolved taken (1-cycle pulse)
//  pc_write       out 1        PC update enable (comb)
//  if_id_write    out 1        IF/ID update enable (comb)
//  ex_valid       out 1        ID/EX holds a real instruction
//  ex_alu_op      out ALUOP_W  registered ALUOp
//  ex_alu_src     out 1        registered ALUSrc
//  ex_branch      out 1        registered Branch
//  ex_mem_read    out 1        registered MemRead
//  ex_mem_write   out 1        registered MemWrite
//  ex_mem_to_reg  out 1        registered MemtoReg
//  ex_reg_write   out 1        registered RegWrite
//  ex_rd          out REG_W    registered destination register
//  illegal_op     out 1        sticky: valid unknown opcode decoded
//  stall_cnt      out CNT_W    saturating count of load-use stall cycles
//  flush_cnt      out CNT_W    saturating count of bubble cycles from flushes
// BEHAVIOUR
//  Reset: all ex_* outputs, illegal_op, counters = 0; FSM = RUN; pc_write = if_id_write = 1.
//  Decode (comb): R 0110011 {src0,m2r0,rw1,rd0,wr0,br0,op10}; LOAD 0000011 {1,1,1,1,0,0,00};
//   STORE 0100011 {1,0,0,0,1,0,00}; BRANCH 1100011 {0,0,0,0,0,1,01}; OP-IMM 0010011 {1,0,1,0,0,0,00}.
//   No X outputs: don't-care fields are driven 0. Any other opcode -> all-zero bundle, illegal.
//  Latency: bundle appears on ex_* 1 clk after the opcode is presented with id_valid=1.
//  Load-use hazard (comb): id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 |
//   (uses_rs2 & ex_rd==id_rs2)); uses_rs2 for R/STORE/BRANCH only. Then pc_write=if_id_write=0,
//   ID/EX loads a bubble (all-zero, ex_valid=0), stall_cnt++. Stall is exactly 1 cycle by construction.
//  FSM RUN/FLUSH with 3-bit counter: branch_taken in RUN -> FLUSH, counter=FLUSH_CYCLES-1, bubble loaded
//   this edge. In FLUSH: bubble each cycle, counter-- ; at 0 -> RUN. flush_cnt++ per bubble.
//   pc_write=if_id_write=1 during flush (fetch continues on new path).
//  Priority: reset > branch_taken > load-use stall > normal. branch_taken in FLUSH restarts the count.
//  id_valid=0 -> bubble loaded, no stall, illegal_op unaffected.
//  Counters saturate at all-ones; no wrap. illegal_op cleared only by reset.
//  Reset asserted mid-flush: FSM to RUN immediately, bubble state, no residual bubbles after release.
// CONFIGURATION
//  CTRL_JUMP_EN defined: adds out ex_jump (1) and ex_jalr (1); decodes JAL 1101111 {rw1,jump1} and
//   JALR 1100111 {src1,rw1,jump1,jalr1}, op 00; jump in ID forces one flush bubble as for branch_taken.
//  Undefined: JAL/JALR are illegal opcodes; ex_jump/ex_jalr ports absent.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams, ALUOp encodings (ALUOP_ADD=00, SUB=01, FUNCT=10),
//   ctrl_t struct of the bundle, CTRL_BUBBLE constant, fsm state enum {RUN, FLUSH}.
//  Sub-module ctrl_decode: pure combinational opcode -> ctrl_t + illegal + uses_rs2.
//  Top holds hazard logic, FSM, ID/EX register, counters.
// TESTING
//  Reset then opcode 0110011 valid -> next clk ex_reg_write=1, ex_alu_op=10, ex_valid=1, others 0.
//  LOAD rd=5 then R-type rs2=5 -> pc_write=0 one cycle, bubble in EX, stall_cnt=1, then R-type issues.
//  LOAD rd=0 then R-type rs1=0 -> no stall; STORE rs2 match does stall, OP-IMM rs2 match does not.
//  FLUSH_CYCLES=2, branch_taken pulse -> 2 bubbles, flush_cnt=2, FSM back to RUN; stall+flush same cycle -> flush wins.
//  Opcode 1111111 valid -> bubble bundle, illegal_op=1 sticky until reset_n low; reset mid-FLUSH -> RUN.
//  CTRL_JUMP_EN: 1101111 -> ex_jump=1, ex_reg_write=1, one flush bubble; undefined -> illegal_op=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ctrl_pkg : opcodes, ALUOp encodings and control bundle for ctrl_decode_pipe |
// | Optional macro CTRL_JUMP_EN adds jump/jalr fields.  Rev 1.0                 |
// +-----------------------------------------------------------------------------+
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
`ifdef CTRL_JUMP_EN
        logic       jump;
        logic       jalr;
`endif
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ctrl_decode : combinational opcode -> control bundle, illegal and uses_rs2  |
// | Optional macro CTRL_JUMP_EN decodes JAL/JALR.  Rev 1.0                      |
// +-----------------------------------------------------------------------------+
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       uses_rs2
);

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        illegal  = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                uses_rs2       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
                uses_rs2    = 1'b1;
            end
            OP_IMM: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
`ifdef CTRL_JUMP_EN
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ctrl_decode_pipe : RV32 ID-stage control, hazard/flush handling, ID/EX reg  |
// | Optional macro CTRL_JUMP_EN adds ex_jump/ex_jalr.  Rev 1.0                  |
// +-----------------------------------------------------------------------------+
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 2,
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_write,
    output logic [REG_W-1:0]   ex_rd,
`ifdef CTRL_JUMP_EN
    output logic               ex_jump,
    output logic               ex_jalr,
`endif
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_t      dec_ctrl;
    logic       dec_illegal;
    logic       dec_uses_rs2;

    ctrl_t      ex_ctrl;
    fsm_state_t state_q;
    fsm_state_t state_d;
    logic [2:0] flush_left_q;
    logic [2:0] flush_left_d;

    logic       load_use;
    logic       flushing;
    logic       stall;
    logic       load_bubble;
    logic       jump_issue;

    ctrl_decode u_decode (
        .opcode   (id_opcode),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .uses_rs2 (dec_uses_rs2)
    );

    // A load in EX whose rd is read by the ID instruction cannot forward in time.
    assign load_use = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (dec_uses_rs2 & (ex_rd == id_rs2)));

    assign flushing    = branch_taken | (state_q == FLUSH);
    assign stall       = load_use & ~flushing;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign load_bubble = flushing | stall | ~id_valid | dec_illegal;

`ifdef CTRL_JUMP_EN
    // The jump itself issues; the following (wrong-path) slot becomes one bubble.
    assign jump_issue = ~load_bubble & dec_ctrl.jump;
`else
    assign jump_issue = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            flush_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    // flush_left counts bubbles still owed after the current edge.
    always_comb begin
        flush_left_d = flush_left_q;
        if (branch_taken) begin
            flush_left_d = FLUSH_RELOAD;
        end else if (state_q == FLUSH) begin
            flush_left_d = flush_left_q - 3'd1;
        end else if (jump_issue) begin
            flush_left_d = 3'd1;
        end
        state_d = (flush_left_d != 3'd0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_valid <= 1'b0;
            ex_rd    <= '0;
        end else if (load_bubble) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_valid <= 1'b0;
            ex_rd    <= '0;
        end else begin
            ex_ctrl  <= dec_ctrl;
            ex_valid <= 1'b1;
            ex_rd    <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_op <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            if (id_valid && dec_illegal) begin
                illegal_op <= 1'b1;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flushing && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign ex_alu_op     = ALUOP_W'(ex_ctrl.alu_op);
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_reg_write  = ex_ctrl.reg_write;
`ifdef CTRL_JUMP_EN
    assign ex_jump       = ex_ctrl.jump;
    assign ex_jalr       = ex_ctrl.jalr;
`endif

endmodule : ctrl_decode_pipe
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ctrl_decode_pipe : vector table, corner sequences and random vs model    |
// | Honours CTRL_JUMP_EN.  Rev 1.0                                              |
// +-----------------------------------------------------------------------------+
module tb_ctrl_decode_pipe;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       branch_taken = 1'b0;
    logic       pc_write, if_id_write, ex_valid;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [4:0] ex_rd;
`ifdef CTRL_JUMP_EN
    logic       ex_jump, ex_jalr;
`endif
    logic          illegal_op;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.ALUOP_W(2), .REG_W(5), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .ex_valid(ex_valid),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
`ifdef CTRL_JUMP_EN
        .ex_jump(ex_jump), .ex_jalr(ex_jalr),
`endif
        .illegal_op(illegal_op), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic       valid;
        logic       src, m2r, rw, mr, mw, br;
        logic       jmp, jalr;
        logic [1:0] op;
        logic [4:0] rd;
    } exp_t;

    exp_t m_ex;
    int   m_left, m_stall, m_flush;
    bit   m_ill;
    logic pcw_seen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic void ref_decode(input logic [6:0] op, output exp_t e,
                                       output bit legal, output bit uses2);
        e = '0; legal = 1'b1; uses2 = 1'b0;
        case (op)
            7'b0110011: begin e.rw = 1; e.op = 2'b10; uses2 = 1; end
            7'b0000011: begin e.src = 1; e.m2r = 1; e.rw = 1; e.mr = 1; end
            7'b0100011: begin e.src = 1; e.mw = 1; uses2 = 1; end
            7'b1100011: begin e.br = 1; e.op = 2'b01; uses2 = 1; end
            7'b0010011: begin e.src = 1; e.rw = 1; end
`ifdef CTRL_JUMP_EN
            7'b1101111: begin e.rw = 1; e.jmp = 1; end
            7'b1100111: begin e.src = 1; e.rw = 1; e.jmp = 1; e.jalr = 1; end
`endif
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic compare_all();
        chk("ex_valid", ex_valid, m_ex.valid);
        chk("ex_alu_op", ex_alu_op, m_ex.op);
        chk("ex_alu_src", ex_alu_src, m_ex.src);
        chk("ex_branch", ex_branch, m_ex.br);
        chk("ex_mem_read", ex_mem_read, m_ex.mr);
        chk("ex_mem_write", ex_mem_write, m_ex.mw);
        chk("ex_mem_to_reg", ex_mem_to_reg, m_ex.m2r);
        chk("ex_reg_write", ex_reg_write, m_ex.rw);
        chk("ex_rd", ex_rd, m_ex.rd);
`ifdef CTRL_JUMP_EN
        chk("ex_jump", ex_jump, m_ex.jmp);
        chk("ex_jalr", ex_jalr, m_ex.jalr);
`endif
        chk("illegal_op", illegal_op, m_ill);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    // One pipeline cycle: drive, check comb enables mid-cycle, clock, check state.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic bt);
        exp_t d;
        bit   legal, u2, hz, fl;
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; branch_taken = bt;
        ref_decode(op, d, legal, u2);
        hz = v && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
             ((m_ex.rd == r1) || (u2 && (m_ex.rd == r2)));
        fl = bt || (m_left > 0);
        #3;
        pcw_seen = pc_write;
        chk("pc_write", pc_write, !(hz && !fl));
        chk("if_id_write", if_id_write, !(hz && !fl));
        @(posedge clk); #1;
        if (v && !legal) m_ill = 1'b1;
        if (bt) begin
            m_ex = '0; m_left = FC - 1; m_flush = sat(m_flush + 1);
        end else if (m_left > 0) begin
            m_ex = '0; m_left--; m_flush = sat(m_flush + 1);
        end else if (hz) begin
            m_ex = '0; m_stall = sat(m_stall + 1);
        end else if (v && legal) begin
            m_ex = d; m_ex.valid = 1'b1; m_ex.rd = rd;
            if (d.jmp) m_left = 1;
        end else begin
            m_ex = '0;
        end
        compare_all();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; id_valid = 1'b0; branch_taken = 1'b0;
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_illegal_op", illegal_op, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
        m_ex = '0; m_left = 0; m_ill = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       e_valid;
        logic [5:0] e_flags;   // {src, m2r, rw, mr, mw, br}
        logic [1:0] e_op;
        logic [4:0] e_rd;
        logic       e_jump;
    } vec_t;

    vec_t vecs[8];
    logic [6:0] ops [0:9];

    initial begin
        int s0, f0;
        vecs[0] = '{1, 7'b0110011, 1, 2, 3, 1, 6'b001000, 2'b10, 3, 0};
        vecs[1] = '{1, 7'b0000011, 1, 2, 5, 1, 6'b111100, 2'b00, 5, 0};
        vecs[2] = '{1, 7'b0100011, 2, 3, 4, 1, 6'b100010, 2'b00, 4, 0};
        vecs[3] = '{1, 7'b1100011, 1, 2, 6, 1, 6'b000001, 2'b01, 6, 0};
        vecs[4] = '{1, 7'b0010011, 1, 2, 7, 1, 6'b101000, 2'b00, 7, 0};
        vecs[5] = '{1, 7'b1111111, 1, 2, 8, 0, 6'b000000, 2'b00, 0, 0};
        vecs[6] = '{0, 7'b0110011, 1, 2, 9, 0, 6'b000000, 2'b00, 0, 0};
`ifdef CTRL_JUMP_EN
        vecs[7] = '{1, 7'b1101111, 1, 2, 1, 1, 6'b001000, 2'b00, 1, 1};
`else
        vecs[7] = '{1, 7'b1101111, 1, 2, 1, 0, 6'b000000, 2'b00, 0, 0};
`endif
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                7'b1101111, 7'b1100111, 7'b1111111, 7'b0000011, 7'b0110011};

        @(posedge clk); #1;
        apply_reset();

        // Single-instruction decode vectors.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].v, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 1'b0);
            chk("tbl_valid", ex_valid, vecs[i].e_valid);
            chk("tbl_flags", {ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                              ex_mem_write, ex_branch}, vecs[i].e_flags);
            chk("tbl_alu_op", ex_alu_op, vecs[i].e_op);
            chk("tbl_rd", ex_rd, vecs[i].e_rd);
`ifdef CTRL_JUMP_EN
            chk("tbl_jump", ex_jump, vecs[i].e_jump);
`endif
        end
        step(1, 7'b0010011, 1, 2, 3, 0);
`ifdef CTRL_JUMP_EN
        chk("jal_flush_bubble", ex_valid, 0);
        chk("jal_flush_cnt", flush_cnt, 1);
`endif
        chk("illegal_sticky", illegal_op, 1);
        step(1, 7'b0110011, 1, 2, 3, 0);
        chk("illegal_still_set", illegal_op, 1);
        apply_reset();

        // Load-use on rs2 of an R-type.
        step(1, 7'b0000011, 1, 2, 5, 0);
        step(1, 7'b0110011, 1, 5, 3, 0);
        chk("lu_pc_write", pcw_seen, 0);
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        step(1, 7'b0110011, 1, 5, 3, 0);
        chk("lu_reissue_pc", pcw_seen, 1);
        chk("lu_reissue_rw", ex_reg_write, 1);
        chk("lu_reissue_valid", ex_valid, 1);

        // rd=0 never stalls; STORE rs2 stalls; OP-IMM rs2 does not.
        apply_reset();
        step(1, 7'b0000011, 1, 2, 0, 0);
        step(1, 7'b0110011, 0, 2, 3, 0);
        chk("x0_no_stall", pcw_seen, 1);
        chk("x0_stall_cnt", stall_cnt, 0);
        step(1, 7'b0000011, 1, 2, 6, 0);
        step(1, 7'b0100011, 1, 6, 0, 0);
        chk("store_rs2_stall", pcw_seen, 0);
        step(1, 7'b0000011, 1, 2, 7, 0);
        step(1, 7'b0010011, 1, 7, 4, 0);
        chk("opimm_rs2_no_stall", pcw_seen, 1);
        chk("opimm_issue", ex_valid, 1);

        // Branch flush: FC bubbles then back to normal issue.
        apply_reset();
        step(1, 7'b0110011, 1, 2, 3, 1);
        chk("flush_b1", ex_valid, 0);
        step(1, 7'b0110011, 1, 2, 3, 0);
        chk("flush_b2", ex_valid, 0);
        chk("flush_cnt2", flush_cnt, 2);
        step(1, 7'b0110011, 1, 2, 3, 0);
        chk("flush_done_issue", ex_valid, 1);
        chk("flush_cnt_hold", flush_cnt, 2);

        // Stall and branch in the same cycle: flush wins.
        step(1, 7'b0000011, 1, 2, 8, 0);
        s0 = stall_cnt; f0 = flush_cnt;
        step(1, 7'b0110011, 8, 2, 3, 1);
        chk("flush_over_stall_pc", pcw_seen, 1);
        chk("flush_over_stall_scnt", stall_cnt, s0);
        chk("flush_over_stall_fcnt", flush_cnt, f0 + 1);

        // Reset while flushing leaves no residual bubble.
        apply_reset();
        step(1, 7'b0110011, 1, 2, 3, 1);
        apply_reset();
        step(1, 7'b0110011, 1, 2, 3, 0);
        chk("no_residual_bubble", ex_valid, 1);

        // Randomised traffic; small register range provokes hazards, counters saturate.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            step($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0);
        end
        chk("stall_saturated", stall_cnt, CMAX);
        chk("flush_saturated", flush_cnt, CMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ctrl_decode_pipe
`default_nettype wire
